sr_ff_bank: RTL and testbench

Parametrised bank of WIDTH independent set/reset flip-flops with a run-time selectable conflict mode: reset-dominant, set-dominant, JK toggle, or hold. Each channel also produces a one-cycle change pulse, and a shared saturating counter tracks how many cycles saw any change. It replaces single-bit SR flip-flops wherever status flags, sticky error bits or control latches are grouped.

---
 rtl/sr_ff_pkg.sv | 32 +++
 rtl/sr_ff_cell.sv | 76 +++++++
 rtl/sr_ff_bank.sv | 62 ++++++
 tb/tb_sr_ff_bank.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sr_ff_pkg.sv
// Shared types and next-state function for the sr_ff_bank set/reset flip-flop bank.
package sr_ff_pkg;

  typedef enum logic [1:0] {
    MODE_RST_DOM = 2'b00,
    MODE_SET_DOM = 2'b01,
    MODE_JK      = 2'b10,
    MODE_HOLD    = 2'b11
  } sr_mode_t;

  // Next Q for one channel given effective set/reset requests and the conflict mode.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_t mode);
    logic q_n;
    q_n = q;
    case ({s, r})
      2'b01:   q_n = 1'b0;
      2'b10:   q_n = 1'b1;
      2'b11: begin
        case (mode)
          MODE_RST_DOM: q_n = 1'b0;
          MODE_SET_DOM: q_n = 1'b1;
          MODE_JK:      q_n = ~q;
          default:      q_n = q;
        endcase
      end
      default: q_n = q;
    endcase
    return q_n;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One channel of sr_ff_bank: optional S/R rising-edge detect, Q/Qb flops and change pulse.
// Edge detection is compiled in with SR_FF_BANK_EDGE_EN.
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_en,
  input  sr_mode_t i_mode,
  input  logic     i_s,
  input  logic     i_r,
  output logic     o_q,
  output logic     o_qb,
  output logic     o_changed,
  output logic     o_chg_c
);

  logic r_q;
  logic r_qb;
  logic r_changed;
  logic w_s;
  logic w_r;
  logic w_q_next;
  logic w_chg;

`ifdef SR_FF_BANK_EDGE_EN
  logic r_s_d;
  logic r_r_d;

  // Request history advances only on enabled edges so a frozen request is not lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s_d <= 1'b0;
      r_r_d <= 1'b0;
    end else if (i_en) begin
      r_s_d <= i_s;
      r_r_d <= i_r;
    end
  end

  assign w_s = i_s & ~r_s_d;
  assign w_r = i_r & ~r_r_d;
`else
  assign w_s = i_s;
  assign w_r = i_r;
`endif

  always_comb begin
    w_q_next = r_q;
    if (i_en) begin
      w_q_next = sr_next(r_q, w_s, w_r, i_mode);
    end
    w_chg = w_q_next ^ r_q;
  end

  // Qb is stored separately, loaded with the complement of the same value as Q.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q       <= RESET_VAL;
      r_qb      <= ~RESET_VAL;
      r_changed <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_qb      <= ~w_q_next;
      r_changed <= w_chg;
    end
  end

  assign o_q       = r_q;
  assign o_qb      = r_qb;
  assign o_changed = r_changed;
  assign o_chg_c   = w_chg;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH set/reset flip-flops with selectable conflict mode and a saturating change counter.
// Optional per-channel rising-edge request detection via SR_FF_BANK_EDGE_EN.
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] w_chg;
  logic             w_any_chg;
  sr_mode_t         w_mode;
  logic [CNT_W-1:0] r_cnt;

  assign w_mode = sr_mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .i_clk     (clk),
      .i_reset   (Reset),
      .i_en      (en),
      .i_mode    (w_mode),
      .i_s       (S[i]),
      .i_r       (R[i]),
      .o_q       (Q[i]),
      .o_qb      (Qb[i]),
      .o_changed (changed[i]),
      .o_chg_c   (w_chg[i])
    );
  end

  assign w_any_chg = |w_chg;

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_any_chg && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign chg_cnt = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed self-checking bench for sr_ff_bank (8-bit counter instance plus a 2-bit counter instance).
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] s;
  logic [7:0] r;
  logic [7:0] q, qb, chg;
  logic [7:0] cnt;
  logic [7:0] q2, qb2, chg2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .Reset(rst), .en(en), .mode(mode), .S(s), .R(r), .clr_cnt(clr),
    .Q(q), .Qb(qb), .changed(chg), .chg_cnt(cnt)
  );

  sr_ff_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'hA5)) dut2 (
    .clk(clk), .Reset(rst), .en(en), .mode(mode), .S(s), .R(r), .clr_cnt(clr),
    .Q(q2), .Qb(qb2), .changed(chg2), .chg_cnt(cnt2)
  );

  task automatic drive(input logic [7:0] sv, input logic [7:0] rv, input logic [1:0] m,
                       input logic e, input logic c);
    s = sv; r = rv; mode = m; en = e; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    drive(8'hFF, 8'h00, 2'b00, 1'b1, 1'b1);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got %h want a5", q); end
    checks++; if (qb !== 8'h5A) begin errors++; $display("FAIL reset_qb got %h want 5a", qb); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL reset_changed got %h want 00", chg); end
    checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h want 00", cnt); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got %h want 0", cnt2); end
    rst = 1'b0;
    drive(8'h01, 8'h00, 2'b00, 1'b1, 1'b0);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL post_reset_q got %h want a5", q); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL post_reset_changed got %h want 00", chg); end
    checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL post_reset_cnt got %h want 00", cnt); end
  endtask

  task automatic test_mode_sweep();
    logic [7:0] exp_q   [4] = '{8'hA4, 8'hA5, 8'hA4, 8'hA4};
    logic [7:0] exp_chg [4] = '{8'h01, 8'h01, 8'h01, 8'h00};
    logic [7:0] exp_cnt [4] = '{8'd1, 8'd2, 8'd3, 8'd3};
    drive(8'h00, 8'h00, 2'b00, 1'b1, 1'b1);
    checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL sweep_clr got %h want 00", cnt); end
    for (int m = 0; m < 4; m++) begin
      drive(8'h01, 8'h01, 2'(m), 1'b1, 1'b0);
      checks++; if (q !== exp_q[m]) begin errors++; $display("FAIL sweep_q mode %0d got %h want %h", m, q, exp_q[m]); end
      checks++; if (qb !== ~exp_q[m]) begin errors++; $display("FAIL sweep_qb mode %0d got %h want %h", m, qb, ~exp_q[m]); end
      checks++; if (chg !== exp_chg[m]) begin errors++; $display("FAIL sweep_changed mode %0d got %h want %h", m, chg, exp_chg[m]); end
      checks++; if (cnt !== exp_cnt[m]) begin errors++; $display("FAIL sweep_cnt mode %0d got %h want %h", m, cnt, exp_cnt[m]); end
      drive(8'h00, 8'h00, 2'(m), 1'b1, 1'b0);
      checks++; if (chg !== 8'h00) begin errors++; $display("FAIL sweep_pulse_end mode %0d got %h want 00", m, chg); end
      checks++; if (q !== exp_q[m]) begin errors++; $display("FAIL sweep_idle_q mode %0d got %h want %h", m, q, exp_q[m]); end
    end
  endtask

  task automatic test_jk();
`ifdef SR_FF_BANK_EDGE_EN
    logic [7:0] exp_q   [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_chg [4] = '{8'hFF, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_cnt [4] = '{8'd1, 8'd1, 8'd1, 8'd1};
`else
    logic [7:0] exp_q   [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [7:0] exp_chg [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_cnt [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
`endif
    drive(8'h00, 8'hFF, 2'b00, 1'b1, 1'b1);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL jk_prep_q got %h want 00", q); end
    checks++; if (chg !== 8'hA4) begin errors++; $display("FAIL jk_prep_changed got %h want a4", chg); end
    checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL jk_clr_priority got %h want 00", cnt); end
    drive(8'h00, 8'h00, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(8'hFF, 8'hFF, 2'b10, 1'b1, 1'b0);
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL jk_q edge %0d got %h want %h", i, q, exp_q[i]); end
      checks++; if (qb !== ~exp_q[i]) begin errors++; $display("FAIL jk_qb edge %0d got %h want %h", i, qb, ~exp_q[i]); end
      checks++; if (chg !== exp_chg[i]) begin errors++; $display("FAIL jk_changed edge %0d got %h want %h", i, chg, exp_chg[i]); end
      checks++; if (cnt !== exp_cnt[i]) begin errors++; $display("FAIL jk_cnt edge %0d got %h want %h", i, cnt, exp_cnt[i]); end
    end
    drive(8'h00, 8'h00, 2'b10, 1'b1, 1'b0);
  endtask

  task automatic test_enable();
`ifdef SR_FF_BANK_EDGE_EN
    logic [7:0] exp_q = 8'hFF;
`else
    logic [7:0] exp_q = 8'h00;
`endif
    drive(8'hFF, 8'h00, 2'b00, 1'b0, 1'b1);
    checks++; if (q !== exp_q) begin errors++; $display("FAIL en0_q got %h want %h", q, exp_q); end
    checks++; if (chg !== 8'h00) begin errors++; $display("FAIL en0_changed got %h want 00", chg); end
    checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL en0_clr got %h want 00", cnt); end
    drive(8'hFF, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++; if (q !== exp_q) begin errors++; $display("FAIL en0_hold_q got %h want %h", q, exp_q); end
    checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL en0_hold_cnt got %h want 00", cnt); end
    drive(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    checks++; if (q !== exp_q) begin errors++; $display("FAIL en1_idle_q got %h want %h", q, exp_q); end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_q    [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [1:0] exp_cnt2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(8'h00, 8'hFF, 2'b00, 1'b1, 1'b1);
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clr got %h want 0", cnt2); end
    drive(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) drive(8'hFF, 8'h00, 2'b00, 1'b1, 1'b0);
      else            drive(8'h00, 8'hFF, 2'b00, 1'b1, 1'b0);
      checks++; if (q2 !== exp_q[i]) begin errors++; $display("FAIL sat_q edge %0d got %h want %h", i, q2, exp_q[i]); end
      checks++; if (cnt2 !== exp_cnt2[i]) begin errors++; $display("FAIL sat_cnt2 edge %0d got %h want %h", i, cnt2, exp_cnt2[i]); end
      checks++; if (cnt !== 8'(i + 1)) begin errors++; $display("FAIL sat_cnt8 edge %0d got %h want %h", i, cnt, 8'(i + 1)); end
    end
    drive(8'h00, 8'hFF, 2'b00, 1'b1, 1'b1);
    checks++; if (q2 !== 8'h00) begin errors++; $display("FAIL sat_clrchg_q got %h want 00", q2); end
    checks++; if (chg2 !== 8'hFF) begin errors++; $display("FAIL sat_clrchg_changed got %h want ff", chg2); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clrchg_cnt2 got %h want 0", cnt2); end
    checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL sat_clrchg_cnt8 got %h want 00", cnt); end
    drive(8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_edge_detect();
    logic [7:0] sv  [8] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08};
    logic [7:0] rv  [8] = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef SR_FF_BANK_EDGE_EN
    logic [7:0] eq  [8] = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
`else
    logic [7:0] eq  [8] = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08};
`endif
    for (int i = 0; i < 8; i++) begin
      drive(sv[i], rv[i], 2'b00, 1'b1, 1'b0);
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL edge_q step %0d got %h want %h", i, q, eq[i]); end
      checks++; if (qb !== ~eq[i]) begin errors++; $display("FAIL edge_qb step %0d got %h want %h", i, qb, ~eq[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00; s = 8'h00; r = 8'h00;
    @(negedge clk);
    test_reset();
    test_mode_sweep();
    test_jk();
    test_enable();
    test_saturation();
    test_edge_detect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
